// File: rtl/router_pkg.sv
// Shared types for the router input port: flit framing, route select codes, port FSM states.
package router_pkg;

  typedef enum logic [1:0] {
    BODY   = 2'b00,
    HEAD   = 2'b01,
    TAIL   = 2'b10,
    SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    SEL_SELF = 2'b00,
    SEL_NS   = 2'b01,
    SEL_WE   = 2'b10,
    SEL_DIAG = 2'b11
  } route_sel_e;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } ip_state_e;

  function automatic logic opens_packet(flit_type_e t);
    return (t == HEAD) || (t == SINGLE);
  endfunction

  function automatic logic closes_packet(flit_type_e t);
    return (t == TAIL) || (t == SINGLE);
  endfunction

endpackage

// File: rtl/router_input_port_if.sv
// Flit handshake bundle between upstream link, input port and output demux.
interface router_input_port_if #(
  parameter int FLIT_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [FLIT_W-1:0] in_flit;
  logic              out_valid;
  logic              out_ready;
  logic [FLIT_W-1:0] out_flit;
  logic [1:0]        out_sel;
  logic              out_dir_x;
  logic              out_dir_y;
  logic              err;

  modport master (
    output in_valid, in_flit, out_ready,
    input  in_ready, out_valid, out_flit, out_sel, out_dir_x, out_dir_y, err
  );

  modport slave (
    input  in_valid, in_flit, out_ready,
    output in_ready, out_valid, out_flit, out_sel, out_dir_x, out_dir_y, err
  );
endinterface

// File: rtl/router_route_calc.sv
// Combinational route select and direction signs for a destination coordinate.
// Zero latency; no handshake.
module router_route_calc
  import router_pkg::*;
#(
  parameter int XW      = 2,
  parameter int YW      = 2,
  parameter int SELFX   = 1,
  parameter int SELFY   = 1,
  parameter int DIAG_EN = 1
) (
  input  logic [XW-1:0] dst_x_i,
  input  logic [YW-1:0] dst_y_i,
  output route_sel_e    sel_o,
  output logic          dir_x_o,
  output logic          dir_y_o
);

  localparam logic [XW-1:0] SX = XW'(SELFX);
  localparam logic [YW-1:0] SY = YW'(SELFY);

  logic eqx, eqy;

  assign eqx     = (dst_x_i == SX);
  assign eqy     = (dst_y_i == SY);
  assign dir_x_o = (dst_x_i > SX);
  assign dir_y_o = (dst_y_i > SY);

  // XY mode resolves x first, so any x mismatch goes west/east.
  always_comb begin
    sel_o = SEL_SELF;
    unique case ({eqx, eqy})
      2'b11:   sel_o = SEL_SELF;
      2'b10:   sel_o = SEL_NS;
      2'b01:   sel_o = SEL_WE;
      default: sel_o = (DIAG_EN != 0) ? SEL_DIAG : SEL_WE;
    endcase
  end

endmodule

// File: rtl/router_input_port.sv
// Buffered router input port: FIFO plus per-packet route latch; head visible 2 cycles after accept.
// in_ready drops when the FIFO is full (no push-through); outputs hold while out_ready is low.
module router_input_port
  import router_pkg::*;
#(
  parameter int FLIT_W  = 32,
  parameter int DEPTH   = 4,
  parameter int XW      = 2,
  parameter int YW      = 2,
  parameter int SELFX   = 1,
  parameter int SELFY   = 1,
  parameter int DIAG_EN = 1
) (
  input logic                  clk,
  input logic                  rst,
  router_input_port_if.slave   ip
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  ip_state_e         state_q, state_d;
  route_sel_e        sel_q, sel_d;
  logic              dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic              err_q, err_d;

  logic              empty, push, pop, out_vld;
  logic [FLIT_W-1:0] head_flit;
  flit_type_e        head_type;
  route_sel_e        calc_sel;
  logic              calc_dir_x, calc_dir_y;

  assign empty     = (count_q == '0);
  assign head_flit = mem_q[rd_ptr_q];
  assign head_type = flit_type_e'(head_flit[FLIT_W-1 -: 2]);
  assign push      = ip.in_valid && ip.in_ready;
  assign out_vld   = (state_q == ACTIVE) && !empty;

  assign ip.in_ready  = (count_q < FULL);
  assign ip.out_valid = out_vld;
  assign ip.out_flit  = head_flit;
  assign ip.out_sel   = sel_q;
  assign ip.out_dir_x = dir_x_q;
  assign ip.out_dir_y = dir_y_q;
  assign ip.err       = err_q;

  router_route_calc #(
    .XW(XW), .YW(YW), .SELFX(SELFX), .SELFY(SELFY), .DIAG_EN(DIAG_EN)
  ) u_route_calc (
    .dst_x_i (head_flit[XW-1:0]),
    .dst_y_i (head_flit[XW+YW-1:XW]),
    .sel_o   (calc_sel),
    .dir_x_o (calc_dir_x),
    .dir_y_o (calc_dir_y)
  );

  // Orphans are popped straight out of IDLE; err is registered so it shows the cycle after.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    err_d   = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          if (opens_packet(head_type)) begin
            sel_d   = calc_sel;
            dir_x_d = calc_dir_x;
            dir_y_d = calc_dir_y;
            state_d = ACTIVE;
          end else begin
            pop   = 1'b1;
            err_d = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (out_vld && ip.out_ready) begin
          pop = 1'b1;
          if (closes_packet(head_type)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
      sel_q    <= SEL_SELF;
      dir_x_q  <= 1'b0;
      dir_y_q  <= 1'b0;
      err_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= ip.in_flit;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      state_q <= state_d;
      sel_q   <= sel_d;
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
      err_q   <= err_d;
    end
  end

endmodule
